// File: rtl/fpu_digit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : fpu_digit_pkg                                          |
// | Purpose : Radix-4 signed-digit encoding shared by the FPU        |
// |           multiplier and divider, plus iteration-count helper.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fpu_digit_pkg;

  // Sign-magnitude digit: bit 2 is the sign, bits 1:0 the magnitude.
  typedef logic [2:0] digit_t;

  localparam digit_t DIGIT_ZERO = 3'b000;
  localparam digit_t DIGIT_POS1 = 3'b001;
  localparam digit_t DIGIT_POS2 = 3'b010;
  localparam digit_t DIGIT_NEG1 = 3'b101;
  localparam digit_t DIGIT_NEG2 = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mult_state_t;

  // Radix-4 digits needed to cover a (size+1)-bit operand.
  function automatic int digit_count(input int size, input bit signed_en);
    if (signed_en)
      return (size + 2) / 2;
    else
      return (size + 3) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_multiplier_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : booth_multiplier_if                                    |
// | Purpose : Start/done handshake and operand/product bus of the    |
// |           Booth mantissa multiplier.                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface booth_multiplier_if
  import fpu_digit_pkg::*;
#(
  parameter int SIZE = 23
);

  logic                start;
  logic [SIZE:0]       multiplicand;
  logic [SIZE:0]       multiplier;
  logic [2*SIZE+1:0]   result;
  logic                done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output result,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : booth_recoder                                          |
// | Purpose : Combinational radix-4 Booth recoding of a 3-bit window |
// |           {b[2i+1], b[2i], b[2i-1]} into a signed digit.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module booth_recoder
  import fpu_digit_pkg::*;
(
  input  wire logic [2:0] i_window,
  output digit_t          o_digit
);

  always_comb begin
    o_digit = DIGIT_ZERO;
    case (i_window)
      3'b001,
      3'b010:  o_digit = DIGIT_POS1;
      3'b011:  o_digit = DIGIT_POS2;
      3'b100:  o_digit = DIGIT_NEG2;
      3'b101,
      3'b110:  o_digit = DIGIT_NEG1;
      default: o_digit = DIGIT_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : booth_multiplier                                       |
// | Purpose : Iterative radix-4 Booth multiplier, one digit/clock.   |
// |           Define BOOTH_MULT_SIGNED_EN for two's complement mode. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module booth_multiplier
  import fpu_digit_pkg::*;
#(
  parameter int SIZE = 23
)
(
  input  wire logic           clk,
  input  wire logic           reset_n,
  booth_multiplier_if.slave   bus
);

`ifdef BOOTH_MULT_SIGNED_EN
  localparam bit c_signed_en = 1'b1;
`else
  localparam bit c_signed_en = 1'b0;
`endif

  localparam int c_op_w   = SIZE + 1;
  localparam int c_acc_w  = 2*SIZE + 4;
  localparam int c_b_w    = SIZE + 4;
  localparam int c_digits = digit_count(SIZE, c_signed_en);
  localparam int c_cnt_w  = (c_digits > 1) ? $clog2(c_digits) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_digits - 1);

  mult_state_t          r_state;
  mult_state_t          w_state_next;
  logic                 w_load;
  logic                 w_step;
  logic                 w_finish;

  logic [c_acc_w-1:0]   r_a;
  logic [c_b_w-1:0]     r_b;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_count;
  logic [2*SIZE+1:0]    r_result;
  logic                 r_done;

  logic                 w_a_fill;
  logic                 w_b_fill;
  logic [c_acc_w-1:0]   w_a_ext;
  logic [c_b_w-1:0]     w_b_ext;
  digit_t               w_digit;
  logic [c_acc_w-1:0]   w_pp;
  logic [c_acc_w-1:0]   w_acc_next;

  // B carries an implicit zero below its LSB; the two top bits are the extension.
  assign w_a_fill = c_signed_en & bus.multiplicand[SIZE];
  assign w_b_fill = c_signed_en & bus.multiplier[SIZE];
  assign w_a_ext  = {{(c_acc_w - c_op_w){w_a_fill}}, bus.multiplicand};
  assign w_b_ext  = {{2{w_b_fill}}, bus.multiplier, 1'b0};

  booth_recoder u_recoder (
    .i_window (r_b[2:0]),
    .o_digit  (w_digit)
  );

  // r_a is pre-scaled by 4^count, so each digit only selects +/-1x or +/-2x.
  always_comb begin
    w_pp = '0;
    case (w_digit)
      DIGIT_POS1: w_pp = r_a;
      DIGIT_POS2: w_pp = r_a << 1;
      DIGIT_NEG1: w_pp = -r_a;
      DIGIT_NEG2: w_pp = -(r_a << 1);
      default:    w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    if (bus.start) begin
      w_load       = 1'b1;
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      w_step = 1'b1;
      if (r_count == c_last) begin
        w_finish     = 1'b1;
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (w_load) begin
      r_a      <= w_a_ext;
      r_b      <= w_b_ext;
      r_acc    <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else if (w_step) begin
      r_a      <= {r_a[c_acc_w-3:0], 2'b00};
      r_b      <= {2'b00, r_b[c_b_w-1:2]};
      r_acc    <= w_acc_next;
      r_count  <= r_count + c_cnt_w'(1);
      if (w_finish) begin
        r_result <= w_acc_next[2*SIZE+1:0];
        r_done   <= 1'b1;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_booth_multiplier                                    |
// | Purpose : Self-checking bench for booth_multiplier (SIZE=23),    |
// |           honours BOOTH_MULT_SIGNED_EN.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_booth_multiplier;

  localparam int SIZE = 23;
`ifdef BOOTH_MULT_SIGNED_EN
  localparam int DIGITS = (SIZE + 2) / 2;
`else
  localparam int DIGITS = (SIZE + 3) / 2;
`endif
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  booth_multiplier_if #(.SIZE(SIZE)) bus ();

  booth_multiplier #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic logic [47:0] model(input logic [23:0] a, input logic [23:0] b);
    longint sa;
    longint sb;
    logic [63:0] prod;
`ifdef BOOTH_MULT_SIGNED_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    sa = longint'({40'd0, a});
    sb = longint'({40'd0, b});
`endif
    prod = 64'(sa * sb);
    return prod[47:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands are scrambled after the start edge; the DUT must not look at them.
  task automatic launch(input logic [23:0] a, input logic [23:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    step();
    bus.start        = 1'b0;
    bus.multiplicand = 24'($urandom());
    bus.multiplier   = 24'($urandom());
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < TIMEOUT) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.result !== 48'd0) $display("FAIL reset_result: got %h expected 0", bus.result);
    else n_pass++;
    bus.start = 1'b0;
    reset_n   = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_idle_done: got %b expected 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [23:0] va [4];
    logic [23:0] vb [4];
    int lat;
`ifdef BOOTH_MULT_SIGNED_EN
    va = '{24'hFFFFFF, 24'h800000, 24'h000003, 24'h000000};
    vb = '{24'hFFFFFF, 24'h7FFFFF, 24'hAAAAAA, 24'h123456};
`else
    va = '{24'hFFFFFF, 24'h000003, 24'h800000, 24'h000000};
    vb = '{24'hFFFFFF, 24'hAAAAAA, 24'h800000, 24'h123456};
`endif
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i]);
      n_checks++;
      if (bus.done !== 1'b0) $display("FAIL dir_done_fall[%0d]: got %b expected 0", i, bus.done);
      else n_pass++;
      wait_done(lat);
      n_checks++;
      if (lat != DIGITS) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, DIGITS);
      else n_pass++;
      n_checks++;
      if (bus.result !== model(va[i], vb[i]))
        $display("FAIL dir_result[%0d]: got %h expected %h", i, bus.result, model(va[i], vb[i]));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [23:0] b;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = 24'($urandom());
      b = 24'($urandom());
      if (i == 0) a = 24'h7FFFFF;
      if (i == 1) b = 24'h800001;
      launch(a, b);
      wait_done(lat);
      n_checks++;
      if (lat != DIGITS || bus.result !== model(a, b))
        $display("FAIL rand[%0d] %h*%h: got %h lat %0d expected %h lat %0d",
                 i, a, b, bus.result, lat, model(a, b), DIGITS);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    int lat;
    saw_done = 1'b0;
    launch(24'd5, 24'd7);
    for (int i = 0; i < 4; i++) begin
      if (bus.done) saw_done = 1'b1;
      step();
    end
    launch(24'd2, 24'd3);
    wait_done(lat);
    n_checks++;
    if (saw_done) $display("FAIL abort_no_done: got done=1 expected 0");
    else n_pass++;
    n_checks++;
    if (lat != DIGITS) $display("FAIL abort_latency: got %0d expected %0d", lat, DIGITS);
    else n_pass++;
    n_checks++;
    if (bus.result !== 48'd6) $display("FAIL abort_result: got %h expected 6", bus.result);
    else n_pass++;
  endtask

  task automatic test_reset_run();
    int lat;
    launch(24'hFFFFFF, 24'hFFFFFF);
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    n_checks++;
    if (bus.done !== 1'b0 || bus.result !== 48'd0)
      $display("FAIL reset_run: got done=%b result=%h expected done=0 result=0", bus.done, bus.result);
    else n_pass++;
    reset_n = 1'b1;
    launch(24'd1, 24'd1);
    wait_done(lat);
    n_checks++;
    if (lat != DIGITS || bus.result !== 48'd1)
      $display("FAIL reset_rerun: got %h lat %0d expected 1 lat %0d", bus.result, lat, DIGITS);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] a1, b1, a2, b2;
    logic [47:0] p1;
    bit held;
    int lat;
    a1 = 24'($urandom());
    b1 = 24'($urandom());
    a2 = 24'($urandom());
    b2 = 24'($urandom());
    p1 = model(a1, b1);
    launch(a1, b1);
    wait_done(lat);
    n_checks++;
    if (bus.result !== p1) $display("FAIL b2b_first: got %h expected %h", bus.result, p1);
    else n_pass++;
    launch(a2, b2);
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL b2b_done_fall: got %b expected 0", bus.done);
    else n_pass++;
    held = 1'b1;
    lat  = 0;
    while (!bus.done && lat < TIMEOUT) begin
      if (bus.result !== p1) held = 1'b0;
      step();
      lat++;
    end
    n_checks++;
    if (!held) $display("FAIL b2b_hold: got changed result expected %h held", p1);
    else n_pass++;
    n_checks++;
    if (lat != DIGITS || bus.result !== model(a2, b2))
      $display("FAIL b2b_second: got %h lat %0d expected %h lat %0d",
               bus.result, lat, model(a2, b2), DIGITS);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [47:0] snap;
    bit stable;
    snap   = bus.result;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.multiplicand = 24'($urandom());
      bus.multiplier   = 24'($urandom());
      step();
      if (bus.done !== 1'b1 || bus.result !== snap) stable = 1'b0;
    end
    n_checks++;
    if (!stable)
      $display("FAIL idle_hold: got done=%b result=%h expected done=1 result=%h", bus.done, bus.result, snap);
    else n_pass++;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_reset_run();
    test_back_to_back();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_multiplier.md
# booth_multiplier

Iterative radix-4 Booth multiplier producing the full-width product of two (SIZE+1)-bit mantissas, retiring one signed digit in {-2,-1,0,+1,+2} per clock. It is the multiply counterpart to the FPU's SRT radix-4 divider: same signed-digit encoding, same start/done handshake and same operand width. It sits in the FPU datapath as the mantissa multiplier feeding normalisation and rounding.

## Interface
- SIZE, 23, MSB index of each operand; operands are SIZE+1 bits, product is 2*SIZE+2 bits
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- start  in  1  load operands and begin; sampled every cycle
- multiplicand  in  SIZE+1  operand A, sampled only on the start edge
- multiplier  in  SIZE+1  operand B, Booth-recoded, sampled only on the start edge
- result  out  2*SIZE+2  registered product A*B
- done  out  1  high while result holds a completed product

## Operation
- States: IDLE, RUN. Reset → IDLE, done=0, result=0, accumulator=0, count=0.
- start=1 (any state, reset_n=1): latch A and B, clear accumulator, count=0, done<=0, go to RUN.
- B extended: unsigned build → two zero bits above MSB plus implicit 0 below LSB; D = ceil((SIZE+2)/2) digits (13 for SIZE=23).
- RUN, each cycle: window {B[2i+1],B[2i],B[2i-1]} (i=count) → digit; accumulator += digit*A*4^i; count += 1.
- Digit encoding (3 bits, sign-magnitude, identical to divider quotient): 000=0, 001=+1, 010=+2, 101=-1, 110=-2. Windows 000/111→0, 001/010→+1, 011→+2, 100→-2, 101/110→-1.
- Accumulator is 2*SIZE+4 bits internally (sign + guard); truncated to 2*SIZE+2 on output. Product exact; no rounding, no overflow possible.
- After digit D-1: result<=accumulator, done<=1, go to IDLE. result and done hold until next start or reset.
- start during RUN: abort, restart with new operands; no done pulse for the aborted operation.
- reset_n=0 overrides start: everything to reset values, IDLE.
- Operand inputs ignored outside the start edge.

## Timing
- Start sampled at edge T; iterations on edges T+1..T+D; done and result visible after edge T+D. Latency D cycles (13 unsigned, 12 signed at SIZE=23).
- done falls after the start edge; result retains the previous product until the completion edge.
- Back-to-back: start may be asserted in the first cycle done is high; throughput one product per D+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- BOOTH_MULT_SIGNED_EN defined: operands two's complement; A sign-extended; B sign-extended by implicit LSB 0 only; D = ceil((SIZE+1)/2) (12 at SIZE=23); result is signed product.
- Undefined (default): operands unsigned, zero-extended as above, D = ceil((SIZE+2)/2).

## Structure
- Shared package fpu_digit_pkg: 3-bit signed-digit typedef and its five constants (shared with the divider), digit-count function of SIZE and signedness.
- Sub-module booth_recoder: combinational 3-bit window → signed digit. Datapath, counter and FSM in booth_multiplier.

## Test plan
- Unsigned, A=0xFFFFFF, B=0xFFFFFF, start one cycle → done exactly 13 cycles later, result=0xFFFFFE000001.
- A=3, B=0xAAAAAA (all -2/+digit windows) → 0x1FFFFFE; A=0x800000, B=0x800000 → 0x400000000000; A=0, B=0x123456 → 0.
- start A=5,B=7; reassert start on iteration 5 with A=2,B=3 → no intermediate done; result=6 at 13 cycles after second start.
- reset_n low during RUN → next cycle done=0, result=0; subsequent start A=B=1 → result=1.
- Back-to-back: start asserted on first done-high cycle → second product correct, first result held until second completion.
- BOOTH_MULT_SIGNED_EN: A=B=0xFFFFFF → 1 after 12 cycles; A=0x800000, B=0x7FFFFF → 0xC00000800000.
